// File: rtl/br_cc_ctrl_pkg.sv
// Shared LC-3b types for the branch / condition-code controller.
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [2:0]  lc3b_nzp;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_CC,
        RESOLVE
    } br_cc_state_t;

    localparam lc3b_nzp CC_RESET   = 3'b010;
    localparam lc3b_nzp NZP_ALWAYS = 3'b111;

endpackage

// File: rtl/br_cc_ctrl_if.sv
// Issue/writeback/branch bundle between control logic and br_cc_ctrl.
// BR_CC_STATS_EN adds the branch statistics counters and their clear.
interface br_cc_ctrl_if;
    import lc3b_types::*;

    logic     cc_issue;
    logic     cc_wr;
    lc3b_word cc_data;
    logic     br_req;
    lc3b_nzp  br_nzp;
    logic     br_ack;
    logic     br_taken;
    lc3b_nzp  cc_out;
    logic     busy;
    logic     cc_ovf;
`ifdef BR_CC_STATS_EN
    logic        stats_clr;
    logic [15:0] br_taken_cnt;
    logic [15:0] br_not_taken_cnt;

    modport master (
        output cc_issue, cc_wr, cc_data, br_req, br_nzp, stats_clr,
        input  br_ack, br_taken, cc_out, busy, cc_ovf, br_taken_cnt, br_not_taken_cnt
    );
    modport slave (
        input  cc_issue, cc_wr, cc_data, br_req, br_nzp, stats_clr,
        output br_ack, br_taken, cc_out, busy, cc_ovf, br_taken_cnt, br_not_taken_cnt
    );
`else
    modport master (
        output cc_issue, cc_wr, cc_data, br_req, br_nzp,
        input  br_ack, br_taken, cc_out, busy, cc_ovf
    );
    modport slave (
        input  cc_issue, cc_wr, cc_data, br_req, br_nzp,
        output br_ack, br_taken, cc_out, busy, cc_ovf
    );
`endif

endinterface

// File: rtl/br_cc_ctrl_gen_cc.sv
// Condition-code generator: exactly one of N/Z/P set for a result word.
module gen_cc
    import lc3b_types::*;
(
    input  lc3b_word word,
    output lc3b_nzp  nzp
);

    assign nzp = {word[15], word == 16'h0000, !word[15] && (word != 16'h0000)};

endmodule

// File: rtl/br_cc_ctrl.sv
// LC-3b CC register owner and branch resolver with pending-writer tracking.
// Optional BR_CC_STATS_EN adds saturating taken/not-taken counters.
module br_cc_ctrl
    import lc3b_types::*;
#(
    parameter int MAX_PENDING = 3
)
(
    input  logic          clk,
    input  logic          reset,
    br_cc_ctrl_if.slave   bus
);

    localparam int CNT_W = $clog2(MAX_PENDING + 1);
    localparam logic [CNT_W-1:0] PEND_MAX = CNT_W'(MAX_PENDING);

    logic [CNT_W-1:0] pending_reg, pending_next;
    logic             ovf_reg, ovf_next;
    lc3b_nzp          cc_reg, cc_gen;
    lc3b_nzp          nzp_reg, nzp_next;
    br_cc_state_t     state_reg, state_next;

    gen_cc u_gen_cc (
        .word (bus.cc_data),
        .nzp  (cc_gen)
    );

    // Issue and writeback in the same cycle cancel; the counter never wraps.
    always_comb begin
        pending_next = pending_reg;
        ovf_next     = ovf_reg;
        case ({bus.cc_issue, bus.cc_wr})
            2'b10: begin
                if (pending_reg == PEND_MAX)
                    ovf_next = 1'b1;
                else
                    pending_next = pending_reg + 1'b1;
            end
            2'b01: begin
                if (pending_reg != '0)
                    pending_next = pending_reg - 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        nzp_next   = nzp_reg;
        case (state_reg)
            IDLE: begin
                if (bus.br_req) begin
                    nzp_next = bus.br_nzp;
                    if (bus.br_nzp == NZP_ALWAYS || pending_next == '0)
                        state_next = RESOLVE;
                    else
                        state_next = WAIT_CC;
                end
            end
            WAIT_CC: begin
                if (pending_next == '0)
                    state_next = RESOLVE;
            end
            RESOLVE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            pending_reg <= '0;
            ovf_reg     <= 1'b0;
            cc_reg      <= CC_RESET;
            nzp_reg     <= 3'b000;
        end else begin
            state_reg   <= state_next;
            pending_reg <= pending_next;
            ovf_reg     <= ovf_next;
            nzp_reg     <= nzp_next;
            if (bus.cc_wr)
                cc_reg <= cc_gen;
        end
    end

    // cc_reg already includes a writeback that landed on the edge entering RESOLVE.
    assign bus.br_ack   = (state_reg == RESOLVE);
    assign bus.br_taken = (state_reg == RESOLVE) && ((cc_reg & nzp_reg) != 3'b000);
    assign bus.busy     = (state_reg != IDLE);
    assign bus.cc_out   = cc_reg;
    assign bus.cc_ovf   = ovf_reg;

`ifdef BR_CC_STATS_EN
    logic [1:0] stat_hit;
    assign stat_hit = {bus.br_ack && !bus.br_taken, bus.br_ack && bus.br_taken};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_stat
            logic [15:0] cnt_reg;
            always_ff @(posedge clk) begin
                if (reset || bus.stats_clr)
                    cnt_reg <= '0;
                else if (stat_hit[gi] && cnt_reg != 16'hFFFF)
                    cnt_reg <= cnt_reg + 1'b1;
            end
        end
    endgenerate

    assign bus.br_taken_cnt     = g_stat[0].cnt_reg;
    assign bus.br_not_taken_cnt = g_stat[1].cnt_reg;
`endif

endmodule

// File: tb/tb_br_cc_ctrl.sv
// Directed plus randomized check of br_cc_ctrl against a transaction-level model.
module tb_br_cc_ctrl;
    import lc3b_types::*;

    localparam int MAXP = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    br_cc_ctrl_if bus ();

    br_cc_ctrl #(.MAX_PENDING(MAXP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Model: outstanding writers, CC value, and the one branch in flight.
    int         m_pend;
    logic [2:0] m_cc;
    logic [2:0] m_nzp;
    bit         m_ovf, m_wait, m_ack, m_taken;
`ifdef BR_CC_STATS_EN
    int m_tcnt, m_ncnt;
    bit stats_clr_v = 1'b0;
`endif

    function automatic logic [2:0] ref_cc(input logic [15:0] d);
        if ($signed(d) < 0) return 3'b100;
        if (d == 16'd0)     return 3'b010;
        return 3'b001;
    endfunction

    task automatic model_step(input bit r, input bit iss, input bit wr,
                              input logic [15:0] d, input bit req, input logic [2:0] nzp);
        bit fire;
        if (r) begin
            m_pend = 0; m_cc = 3'b010; m_ovf = 0; m_wait = 0; m_ack = 0; m_taken = 0;
`ifdef BR_CC_STATS_EN
            m_tcnt = 0; m_ncnt = 0;
`endif
            return;
        end
`ifdef BR_CC_STATS_EN
        if (stats_clr_v) begin
            m_tcnt = 0; m_ncnt = 0;
        end else if (m_ack) begin
            if (m_taken) m_tcnt = (m_tcnt < 65535) ? m_tcnt + 1 : m_tcnt;
            else         m_ncnt = (m_ncnt < 65535) ? m_ncnt + 1 : m_ncnt;
        end
`endif
        if (iss && !wr) begin
            if (m_pend == MAXP) m_ovf = 1;
            else m_pend++;
        end else if (wr && !iss && m_pend > 0) begin
            m_pend--;
        end
        if (wr) m_cc = ref_cc(d);
        fire = 0;
        if (m_ack) begin
            fire = 0;
        end else if (m_wait) begin
            if (m_pend == 0) begin fire = 1; m_wait = 0; end
        end else if (req) begin
            m_nzp = nzp;
            if (nzp == 3'b111 || m_pend == 0) fire = 1;
            else m_wait = 1;
        end
        m_ack   = fire;
        m_taken = fire && ((m_cc & m_nzp) != 3'b000);
        if (fire) $display("txn: nzp=%b cc=%b taken=%0d", m_nzp, m_cc, m_taken);
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("br_ack",   16'(bus.br_ack),   16'(m_ack));
        check("br_taken", 16'(bus.br_taken), 16'(m_taken));
        check("busy",     16'(bus.busy),     16'(m_wait || m_ack));
        check("cc_out",   16'(bus.cc_out),   16'(m_cc));
        check("cc_ovf",   16'(bus.cc_ovf),   16'(m_ovf));
`ifdef BR_CC_STATS_EN
        check("taken_cnt",     bus.br_taken_cnt,     16'(m_tcnt));
        check("not_taken_cnt", bus.br_not_taken_cnt, 16'(m_ncnt));
`endif
    endtask

    task automatic cyc(input bit r, input bit iss, input bit wr,
                       input logic [15:0] d, input bit req, input logic [2:0] nzp);
        @(negedge clk);
        reset        = r;
        bus.cc_issue = iss;
        bus.cc_wr    = wr;
        bus.cc_data  = d;
        bus.br_req   = req;
        bus.br_nzp   = nzp;
`ifdef BR_CC_STATS_EN
        bus.stats_clr = stats_clr_v;
`endif
        @(posedge clk);
        model_step(r, iss, wr, d, req, nzp);
        #1;
        check_all();
    endtask

    task automatic idle();
        cyc(0, 0, 0, 16'h0, 0, 3'b000);
    endtask

    task automatic do_reset();
        cyc(1, 0, 0, 16'h0, 0, 3'b000);
        cyc(1, 0, 0, 16'h0, 0, 3'b000);
    endtask

    bit          r_v, iss_v, wr_v, hold;
    logic [15:0] d_v;
    logic [2:0]  hn;

    initial begin
        reset = 1'b1;
        bus.cc_issue = 0; bus.cc_wr = 0; bus.cc_data = '0; bus.br_req = 0; bus.br_nzp = '0;
`ifdef BR_CC_STATS_EN
        bus.stats_clr = 0;
`endif
        // No pending writers: ack the next cycle, Z taken.
        do_reset();
        cyc(0, 0, 0, 16'h0, 1, 3'b010);
        cyc(0, 0, 0, 16'h0, 1, 3'b010);
        idle();

        // One writer; branch waits until the negative result lands.
        do_reset();
        cyc(0, 1, 0, 16'h0, 0, 3'b000);
        cyc(0, 0, 0, 16'h0, 1, 3'b100);
        cyc(0, 0, 0, 16'h0, 1, 3'b100);
        cyc(0, 0, 0, 16'h0, 1, 3'b100);
        cyc(0, 0, 1, 16'h8001, 1, 3'b100);
        cyc(0, 0, 0, 16'h0, 1, 3'b100);
        idle();

        // Unconditional ignores two pending writers; the count survives it.
        do_reset();
        cyc(0, 1, 0, 16'h0, 0, 3'b000);
        cyc(0, 1, 0, 16'h0, 0, 3'b000);
        cyc(0, 0, 0, 16'h0, 1, 3'b111);
        cyc(0, 0, 0, 16'h0, 1, 3'b111);
        cyc(0, 0, 0, 16'h0, 1, 3'b010);
        cyc(0, 0, 1, 16'h0005, 1, 3'b010);
        cyc(0, 0, 1, 16'h0000, 1, 3'b010);
        cyc(0, 0, 0, 16'h0, 1, 3'b010);
        idle();

        // Simultaneous issue and writeback keep the wait going.
        do_reset();
        cyc(0, 1, 0, 16'h0, 0, 3'b000);
        cyc(0, 0, 0, 16'h0, 1, 3'b010);
        cyc(0, 1, 1, 16'h0007, 1, 3'b010);
        cyc(0, 0, 0, 16'h0, 1, 3'b010);
        cyc(0, 0, 1, 16'h0000, 1, 3'b010);
        cyc(0, 0, 0, 16'h0, 1, 3'b010);
        idle();

        // Saturation sets a sticky overflow; zero mask resolves not-taken.
        do_reset();
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 16'h0, 0, 3'b000);
        idle();
        cyc(0, 0, 1, 16'h0001, 0, 3'b000);
        cyc(0, 0, 0, 16'h0, 1, 3'b000);
        cyc(0, 0, 1, 16'h0001, 1, 3'b000);
        cyc(0, 0, 1, 16'h0001, 1, 3'b000);
        cyc(0, 0, 0, 16'h0, 1, 3'b000);
        idle();
        do_reset();
        idle();

        // Reset in WAIT_CC drops the request.
        cyc(0, 1, 0, 16'h0, 0, 3'b000);
        cyc(0, 0, 1, 16'hFFFF, 1, 3'b001);
        cyc(0, 1, 0, 16'h0, 1, 3'b001);
        cyc(0, 0, 0, 16'h0, 1, 3'b001);
        cyc(1, 0, 0, 16'h0, 1, 3'b001);
        idle();
        idle();

`ifdef BR_CC_STATS_EN
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, 16'h0, 1, (i < 3) ? 3'b010 : 3'b101);
            cyc(0, 0, 0, 16'h0, 1, (i < 3) ? 3'b010 : 3'b101);
            idle();
        end
        stats_clr_v = 1'b1;
        idle();
        stats_clr_v = 1'b0;
        idle();
`endif

        // Randomized traffic; branch requests held until acknowledged.
        do_reset();
        hold = 0;
        hn   = 3'b000;
        for (int i = 0; i < 600; i++) begin
            r_v   = ($urandom_range(0, 99) == 0);
            iss_v = ($urandom_range(0, 3) == 0);
            wr_v  = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 3))
                0:       d_v = 16'h0000;
                1:       d_v = 16'h8000 | 16'($urandom);
                default: d_v = 16'($urandom);
            endcase
            if (!hold && $urandom_range(0, 2) == 0) begin
                hold = 1;
                hn   = 3'($urandom);
            end
`ifdef BR_CC_STATS_EN
            stats_clr_v = ($urandom_range(0, 49) == 0);
`endif
            cyc(r_v, iss_v, wr_v, d_v, hold, hn);
            if (m_ack || r_v) hold = 0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
